// File: rtl/main_memory_responder_pkg.sv
// Shared types for the main-memory responder. The operation encoding is the
// one the cache controller's hmem requester drives (mirrors torrence_types).
package main_memory_responder_pkg;

    typedef enum logic [1:0] {
        LOAD       = 2'd0,
        STORE      = 2'd1,
        CLFLUSH    = 2'd2,
        MO_UNKNOWN = 2'd3
    } memory_operation_e;

    // Number of low address bits that select a byte within one word.
    function automatic int byte_offset_bits(input int word_width);
        return $clog2(word_width / 8);
    endfunction

endpackage

// File: rtl/main_memory_responder_checker.sv
// Protocol properties of the responder, kept apart from the datapath.
module main_memory_responder_checker
    import main_memory_responder_pkg::*;
(
    input logic       i_clk,
    input logic       i_rst,
    input logic       i_accept,
    input logic [1:0] i_operation,
    input logic       i_fulfilled
);

    a_op_known: assert property (@(posedge i_clk) disable iff (i_rst)
        i_accept |-> (i_operation != MO_UNKNOWN));

    a_single_pulse: assert property (@(posedge i_clk) disable iff (i_rst)
        i_fulfilled |=> !i_fulfilled);

endmodule

// File: rtl/main_memory_responder_memory_array.sv
// Backing store: single port, synchronous write, combinational read.
// Contents are deliberately not reset.
module main_memory_responder_memory_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WORD_WIDTH  = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_index,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    output logic [WORD_WIDTH-1:0] o_rdata
);

    logic [WORD_WIDTH-1:0] r_mem [DEPTH_WORDS];

    // Word write at the addressed index
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_index] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_index];

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency main-memory model answering a cache controller's hmem port:
// one request at a time, fulfilled exactly LATENCY cycles after acceptance.
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int WORD_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    input  logic [1:0]            i_req_operation,
    input  logic [ADDR_WIDTH-1:0] i_req_address,
    input  logic [WORD_WIDTH-1:0] i_req_store_word,
    output logic [WORD_WIDTH-1:0] o_req_loaded_word,
    output logic                  o_req_fulfilled
);

    localparam int BYTE_OFF = byte_offset_bits(WORD_WIDTH);
    localparam int IDX_W    = $clog2(DEPTH_WORDS);
    localparam int CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);
    localparam bit DIRECT_RESPOND = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    memory_operation_e     r_op;
    logic [IDX_W-1:0]      r_index;
    logic [WORD_WIDTH-1:0] r_store_word;
    logic [WORD_WIDTH-1:0] r_loaded_word;
    logic [WORD_WIDTH-1:0] w_loaded_word;
    logic [WORD_WIDTH-1:0] w_rdata;
    logic [IDX_W-1:0]      w_index;
    logic                  w_accept;
    logic                  w_we;
    logic                  w_fulfilled;
    logic                  w_unused_addr;

    // Upper address bits wrap silently; only the word-index slice matters.
    assign w_index       = i_req_address[BYTE_OFF +: IDX_W];
    assign w_unused_addr = ^i_req_address;

    // State, latency counter and held load data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_loaded_word <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_loaded_word <= w_loaded_word;
        end
    end

    // Request capture; inputs are ignored after acceptance
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op         <= LOAD;
            r_index      <= '0;
            r_store_word <= '0;
        end else if (w_accept) begin
            r_op         <= memory_operation_e'(i_req_operation);
            r_index      <= w_index;
            r_store_word <= i_req_store_word;
        end
    end

    // Next state, counter and Moore outputs
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_accept      = 1'b0;
        w_we          = 1'b0;
        w_fulfilled   = 1'b0;
        w_loaded_word = r_loaded_word;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = CNT_START;
                    w_state_next = DIRECT_RESPOND ? ST_RESPOND : ST_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!i_req_valid) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_state_next = ST_RESPOND;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt - CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                w_fulfilled  = 1'b1;
                w_state_next = ST_IDLE;
                if (r_op == STORE) begin
                    w_we = 1'b1;
                end else if (r_op == LOAD) begin
                    w_loaded_word = w_rdata;
                end else begin
                    w_we = 1'b0;
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_cnt_next    = '0;
                w_fulfilled   = 1'bx;
                w_loaded_word = {WORD_WIDTH{1'bx}};
            end
        endcase
    end

    assign o_req_fulfilled   = w_fulfilled;
    assign o_req_loaded_word = w_loaded_word;

    main_memory_responder_memory_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WORD_WIDTH  (WORD_WIDTH),
        .IDX_W       (IDX_W)
    ) u_memory_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_index (r_index),
        .i_wdata (r_store_word),
        .o_rdata (w_rdata)
    );

    main_memory_responder_checker u_checker (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_accept    (w_accept),
        .i_operation (i_req_operation),
        .i_fulfilled (o_req_fulfilled)
    );

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench: a LATENCY=4 instance (index 0) and a LATENCY=1 instance (index 1).
module tb_main_memory_responder;
    import main_memory_responder_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  valid = 2'b00;
    logic [1:0]  op   [2];
    logic [31:0] addr [2];
    logic [31:0] data [2];
    logic [31:0] loaded [2];
    logic [1:0]  fulfilled;
    logic [31:0] last [2];
    logic [1:0]  prev = 2'b00;
    exp_t        q [2][$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    main_memory_responder #(.LATENCY(4), .DEPTH_WORDS(1024), .WORD_WIDTH(32)) u_dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req_valid       (valid[0]),
        .i_req_operation   (op[0]),
        .i_req_address     (addr[0]),
        .i_req_store_word  (data[0]),
        .o_req_loaded_word (loaded[0]),
        .o_req_fulfilled   (fulfilled[0])
    );

    main_memory_responder #(.LATENCY(1), .DEPTH_WORDS(1024), .WORD_WIDTH(32)) u_dut_l1 (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req_valid       (valid[1]),
        .i_req_operation   (op[1]),
        .i_req_address     (addr[1]),
        .i_req_store_word  (data[1]),
        .o_req_loaded_word (loaded[1]),
        .o_req_fulfilled   (fulfilled[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every fulfilled pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (fulfilled[i] === 1'b1) begin
                n_cmp++;
                if (prev[i]) begin
                    n_fail++;
                    $display("FAIL pulse_width dut%0d: fulfilled high two cycles at cyc %0d", i, cyc);
                end
                if (q[i].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_fulfilled dut%0d: got pulse at cyc %0d, expected none", i, cyc);
                end else begin
                    e = q[i].pop_front();
                    n_cmp++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL latency dut%0d: got cyc %0d, expected cyc %0d", i, cyc, e.cyc);
                    end
                    n_cmp++;
                    if (loaded[i] !== e.word) begin
                        n_fail++;
                        $display("FAIL loaded_word dut%0d: got %h, expected %h", i, loaded[i], e.word);
                    end
                end
            end
            prev[i] = (fulfilled[i] === 1'b1);
        end
    end

    // Present a request now (just after a posedge) and wait for its pulse
    task automatic issue(input int d, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_load, input bit perturb);
        int n;
        op[d]    = o;
        addr[d]  = a;
        data[d]  = wd;
        valid[d] = 1'b1;
        if (o == LOAD) last[d] = exp_load;
        q[d].push_back('{cyc + ((d == 0) ? 4 : 1), last[d]});
        if (perturb) begin
            repeat (2) begin @(posedge clk); #1; end
            addr[d] = 32'h60;
            data[d] = 32'h0;
            op[d]   = LOAD;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fulfilled[d] !== 1'b1 && n < 40);
        if (fulfilled[d] !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout dut%0d: no fulfilled for addr %h, expected one", d, a);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            op[i] = LOAD; addr[i] = 32'h0; data[i] = 32'h0; last[i] = 32'h0;
        end
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        for (int i = 0; i < 2; i++) begin
            check_val("reset_fulfilled", {31'h0, fulfilled[i]}, 32'h0);
            check_val("reset_loaded", loaded[i], 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Store/load with valid held, first acceptance right after reset
        issue(0, STORE, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(0, LOAD,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        valid[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_val("loaded_hold", loaded[0], 32'hDEADBEEF);

        // Line fill: four stores then four loads, address stepped per pulse
        for (int i = 0; i < 4; i++)
            issue(0, STORE, 32'h100 + 32'(4 * i), 32'h11110000 + 32'(i), 32'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            issue(0, LOAD, 32'h100 + 32'(4 * i), 32'h0, 32'h11110000 + 32'(i), 1'b0);

        // Address wrap: 0x1004 and 0x0004 share word index 1
        issue(0, STORE, 32'h1004, 32'h1, 32'h0, 1'b0);
        issue(0, LOAD,  32'h0004, 32'h0, 32'h1, 1'b0);

        // CLFLUSH leaves storage and loaded word untouched
        issue(0, STORE,   32'h30, 32'h7, 32'h0, 1'b0);
        issue(0, CLFLUSH, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b0);
        issue(0, LOAD,    32'h30, 32'h0, 32'h7, 1'b0);

        // Inputs scrambled while waiting must not matter
        issue(0, STORE, 32'h50, 32'h99, 32'h0, 1'b1);
        issue(0, LOAD,  32'h50, 32'h0, 32'h99, 1'b0);

        // Reset on cycle 2 of a store abandons it
        issue(0, STORE, 32'h20, 32'h11, 32'h0, 1'b0);
        op[0] = STORE; addr[0] = 32'h20; data[0] = 32'h55; valid[0] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check_val("midreset_fulfilled", {31'h0, fulfilled[0]}, 32'h0);
        check_val("midreset_loaded", loaded[0], 32'h0);
        last[0] = 32'h0;
        last[1] = 32'h0;
        valid[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        issue(0, LOAD, 32'h20, 32'h0, 32'h11, 1'b0);

        // Valid dropped while waiting: no write, no pulse, back to idle
        op[0] = STORE; addr[0] = 32'h10; data[0] = 32'hBAD; valid[0] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        valid[0] = 1'b0;
        @(posedge clk); #1;
        issue(0, LOAD, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        valid[0] = 1'b0;

        // LATENCY=1 instance: pulse on the cycle after acceptance
        issue(1, STORE, 32'h40, 32'hA5A5A5A5, 32'h0, 1'b0);
        issue(1, LOAD,  32'h40, 32'h0, 32'hA5A5A5A5, 1'b0);
        valid[1] = 1'b0;

        repeat (8) begin @(posedge clk); #1; end
        for (int i = 0; i < 2; i++)
            check_val("pending_expectations", 32'(q[i].size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
